hilo_div_unit: RTL and testbench
================================

Name: hilo_div_unit

Overview:
- Multi-cycle, iterative (radix-2 restoring) integer divider for DIV/DIVU.
- Sits in the execute stage beside the ALU. Its quotient and remainder feed the existing LO/HI write path through the M-stage hilo register.
- Width is parametrised and the unit supports signed and unsigned modes.
- Exposes a start/busy/done handshake that the hazard unit uses to stall F/D/E, and a cancel input for pipeline flushes.

Parameters:
- WIDTH, 32, operand/result width in bits (WIDTH >= 4, power of two not required).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low: all state cleared on a rising clk edge while rst==0.
- start  in  1  request a division; sampled only in IDLE.
- signed_div  in  1  1 = DIV (two's-complement), 0 = DIVU; sampled with start.
- cancel  in  1  abort the current operation (flushE / exception); no result is produced.
- a  in  WIDTH  dividend; sampled with start.
- b  in  WIDTH  divisor; sampled with start.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; quotient and remainder are valid in that cycle.
- div_by_zero  out  1  qualifies done: the divisor was 0.
- quotient  out  WIDTH  result, goes to LO.
- remainder  out  WIDTH  result, goes to HI.

Behaviour:
- Reset (rst==0 at an edge): state=IDLE, counter=0; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0.
- States: IDLE, ITER, FIX, DONE.
- IDLE:
  - start=1 and cancel=0 at an edge: latch |a| and |b| (magnitudes taken only if signed_div=1), latch sign_q = a[W-1]^b[W-1] and sign_r = a[W-1] (both forced to 0 when unsigned), latch b==0. Then counter=0 and go to ITER.
  - Otherwise stay in IDLE.
- ITER:
  - Each edge performs one restoring step: shift {rem,quo} left by 1, trial-subtract the divisor, set the quotient bit when the result is >= 0.
  - counter increments each edge. After WIDTH steps (counter==WIDTH-1 at the edge) go to FIX.
- FIX (one edge):
  - Negate the quotient if sign_q and the remainder if sign_r.
  - Register the results into quotient/remainder and go to DONE.
- DONE: done=1 for exactly this cycle; next edge goes to IDLE. start is ignored in DONE.
- Latency: start sampled at edge k gives done high in the cycle following edge k+WIDTH+1, i.e. WIDTH+2 cycles; 34 for WIDTH=32. Latency is fixed for all operands, including divide-by-zero.
- quotient/remainder hold their values after done until the next FIX edge. They are unaffected by cancel.
- Divide by zero: quotient = all ones, remainder = a as sampled, div_by_zero=1 with done, at normal latency. The restoring algorithm with divisor 0 yields this naturally in unsigned mode. In signed mode the FIX stage forces these values.
- Signed overflow (a = most-negative, b = -1): quotient = most-negative, remainder = 0. This falls out of the magnitude arithmetic, and no special case is required.
- Arithmetic:
  - Partial remainder is WIDTH+1 bits so the trial-subtract sign bit is kept.
  - Magnitude of the most-negative value is taken as an unsigned WIDTH-bit value 2^(W-1).
- cancel=1 at any edge in ITER/FIX/DONE: go to IDLE at that edge; done stays 0 (or drops if in DONE). cancel has priority over start in IDLE.
- start while busy: ignored; no queueing.
- rst==0 mid-operation overrides cancel and all state at that edge.
- The hazard unit stalls on busy & ~done; the E-stage instruction is released in the done cycle.

Decomposition:
- Shared package (alongside defines2.vh): state encodings DIV_IDLE/DIV_ITER/DIV_FIX/DIV_DONE (2 bits).
- One combinational sub-module, div_restore_step (WIDTH param): inputs are partial rem, quo and divisor; outputs are the next rem and quo. It is instantiated once, and the FSM/counter/sign logic stays in hilo_div_unit.

Test Plan:
- Unsigned: signed_div=0, a=100, b=7, start 1 cycle -> busy next cycle, done exactly 34 cycles after the start edge, quotient=14, remainder=2, div_by_zero=0.
- Signed: a=-7 (0xFFFFFFF9), b=2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); and a=7, b=-2 -> quotient=-3, remainder=1.
- Edge values:
  - a=0x80000000, b=0xFFFFFFFF signed -> quotient=0x80000000, remainder=0.
  - Same operands unsigned -> quotient=0, remainder=0x80000000.
- Divide by zero: a=0x1234, b=0, either mode -> done at cycle 34, div_by_zero=1, quotient=0xFFFFFFFF, remainder=0x1234.
- Control:
  - cancel at cycle 10 of an operation -> busy=0 next edge, no done; a new start 1 cycle later gives a correct result at the full latency.
  - start held high during busy -> ignored.
  - rst=0 at cycle 5 -> all outputs 0 next edge.
- WIDTH=8 instance, signed a=-128, b=3 -> done at cycle 10, quotient=-42 (0xD6), remainder=-2 (0xFE).

Source files
------------

// File: rtl/hilo_div_unit_pkg.sv
// rtl/hilo_div_unit_pkg.sv - shared state encodings for the HI/LO divider
package hilo_div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ITER = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/hilo_div_unit_restore_step.sv
// rtl/hilo_div_unit_restore_step.sv - one combinational radix-2 restoring division step
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    // The shifted partial remainder is WIDTH+1 bits so the trial-subtract
    // borrow lands in the top bit. The kept remainder is always below the
    // divisor, so it fits back into WIDTH bits.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           fits;

    // Shift in the next dividend bit, trial-subtract, restore on borrow
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        trial    = shifted - {1'b0, divisor};
        fits     = ~trial[WIDTH];
        rem_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/hilo_div_unit.sv
// rtl/hilo_div_unit.sv - iterative signed/unsigned divider feeding the HI/LO path
module hilo_div_unit
    import hilo_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t       state;
    div_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             sign_q;
    logic             sign_r;
    logic             dz_q;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             last_iter;
    logic             accept;

    // Negating the most-negative value wraps to itself, which read as
    // unsigned is exactly its magnitude 2^(WIDTH-1).
    assign a_mag     = (signed_div && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag     = (signed_div && b[WIDTH-1]) ? (~b + 1'b1) : b;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign accept    = start && !cancel;

    assign busy        = (state != DIV_IDLE);
    assign done        = (state == DIV_DONE);
    assign div_by_zero = done && dz_q;

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (rem_nxt),
        .quo_next (quo_nxt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; cancel wins everywhere, start only counts in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (accept) state_nxt = DIV_ITER;
            DIV_ITER: begin
                if (cancel) begin
                    state_nxt = DIV_IDLE;
                end else if (last_iter) begin
                    state_nxt = DIV_FIX;
                end
            end
            DIV_FIX:  state_nxt = cancel ? DIV_IDLE : DIV_DONE;
            DIV_DONE: state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    // Operand capture, iteration and sign fix-up of the results
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            dz_q      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        rem_q  <= '0;
                        quo_q  <= a_mag;
                        dvs_q  <= b_mag;
                        sign_q <= signed_div && (a[WIDTH-1] ^ b[WIDTH-1]);
                        sign_r <= signed_div && a[WIDTH-1];
                        dz_q   <= (b == '0);
                    end
                end
                DIV_ITER: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt   <= cnt + 1'b1;
                end
                DIV_FIX: begin
                    // A zero divisor leaves all-ones / |a| in the datapath;
                    // the quotient sign flip must not apply to it, while
                    // negating |a| by sign_r restores a as sampled.
                    if (!cancel) begin
                        if (dz_q) begin
                            quotient <= '1;
                        end else begin
                            quotient <= sign_q ? (~quo_q + 1'b1) : quo_q;
                        end
                        remainder <= sign_r ? (~rem_q + 1'b1) : rem_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_unit.sv
// tb/tb_hilo_div_unit.sv - directed self-checking bench for hilo_div_unit
module tb_hilo_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, signed_div, cancel;
    logic [31:0] a, b;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    logic        start8, signed_div8, cancel8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, div_by_zero8;
    logic [7:0]  quotient8, remainder8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hilo_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_div  (signed_div),
        .cancel      (cancel),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    hilo_div_unit #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .signed_div  (signed_div8),
        .cancel      (cancel8),
        .a           (a8),
        .b           (b8),
        .busy        (busy8),
        .done        (done8),
        .div_by_zero (div_by_zero8),
        .quotient    (quotient8),
        .remainder   (remainder8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Launch one 32-bit division and check latency, results and the return to idle.
    // n counts edges after the start edge; done must appear after WIDTH+1 of them.
    task automatic run32(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz,
                         input logic hold, input string tag);
        int n;
        @(negedge clk);
        start = 1'b1; signed_div = sd; a = av; b = bv;
        @(negedge clk);
        if (hold) begin
            a = 32'hDEAD_BEEF; b = 32'h1; signed_div = ~sd;
        end else begin
            start = 1'b0;
        end
        chk({tag, "_busy"}, {31'b0, busy}, 32'h1);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk({tag, "_lat"}, 32'(n), 32'd33);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dz"}, {31'b0, div_by_zero}, {31'b0, edz});
        @(negedge clk);
        chk({tag, "_idle"}, {30'b0, busy, done}, 32'h0);
    endtask

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; signed_div = 1'b0; cancel = 1'b0; a = '0; b = '0;
        start8 = 1'b0; signed_div8 = 1'b0; cancel8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_dz", {31'b0, div_by_zero}, 32'h0);
        chk("rst_q", quotient, 32'h0);
        chk("rst_r", remainder, 32'h0);
        rst = 1'b1;

        run32(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, "udiv");
        run32(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, "sdiv_neg_a");
        run32(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, "sdiv_neg_b");
        run32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 1'b0, "sovf");
        run32(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0, "uovf");
        run32(1'b0, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0, "udz");
        run32(1'b1, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0, "sdz");

        // Cancel ten cycles into an operation; previous results must be held
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; a = 32'd999; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", {31'b0, busy}, 32'h0);
        chk("cancel_done", {31'b0, done}, 32'h0);
        chk("cancel_hold_q", quotient, 32'hFFFF_FFFF);
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("cancel_no_done", 32'(n), 32'h0);
        run32(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b0, "after_cancel");

        // start held high and operands scrambled while busy
        run32(1'b0, 32'd50, 32'd6, 32'd8, 32'd2, 1'b0, 1'b1, "hold_start");

        // Reset in the middle of an operation
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; a = 32'd77; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        chk("midrst_done", {31'b0, done}, 32'h0);
        chk("midrst_q", quotient, 32'h0);
        chk("midrst_r", remainder, 32'h0);
        rst = 1'b1;

        // 8-bit instance: -128 / 3
        @(negedge clk);
        start8 = 1'b1; signed_div8 = 1'b1; a8 = 8'h80; b8 = 8'd3;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("w8_lat", 32'(n), 32'd9);
        chk("w8_q", {24'b0, quotient8}, 32'hD6);
        chk("w8_r", {24'b0, remainder8}, 32'hFE);
        chk("w8_dz", {31'b0, div_by_zero8}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
